// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Brings subsystems out of reset in a fixed order once the PLL
//               has locked. Each stage enable rises STAGE_DELAY cycles after
//               the previous one, and `ready` rises with the last stage. A
//               lock timeout pulses the PLL reset and retries. When the
//               retries run out the block enters a fault state, and
//               soft_rst_req clears that fault. soft_rst_req also
//               re-sequences a running system.
//
// Ports       : clk          in   system clock, posedge
//               rst          in   synchronous active-high reset
//               pll_locked   in   PLL lock flag (clk domain)
//               soft_rst_req in   re-sequence / fault-clear request
//               stage_en     out  thermometer stage enables, bit 0 first
//               ready        out  all stages enabled
//               pll_rst      out  PLL reset request
//               fault        out  lock never achieved within retries
//               retry_cnt    out  PLL retries consumed in this attempt
//
// Options     : RSEQ_LOCK_MONITOR_EN - when defined, a loss of lock while
//               running triggers a soft re-sequence.
//
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
    parameter int NUM_STAGES   = 4,
    parameter int STAGE_DELAY  = 16,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int SOFT_HOLD    = 8,
    parameter int MAX_RETRY    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_locked,
    input  logic                  soft_rst_req,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic                  ready,
    output logic                  pll_rst,
    output logic                  fault,
    output logic [1:0]            retry_cnt
);

    localparam logic [2:0] c_ST_HOLD      = 3'd0;
    localparam logic [2:0] c_ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] c_ST_PLL_RESET = 3'd2;
    localparam logic [2:0] c_ST_STAGE     = 3'd3;
    localparam logic [2:0] c_ST_RUN       = 3'd4;
    localparam logic [2:0] c_ST_SOFT      = 3'd5;
    localparam logic [2:0] c_ST_FAULT     = 3'd6;

    // Terminal timer values. The timer counts from 0, so each dwell ends
    // on the edge that sees the value one below the configured length.
    localparam logic [31:0] c_LOCK_LAST  = 32'(LOCK_TIMEOUT - 1);
    localparam logic [31:0] c_HOLD_LAST  = 32'(SOFT_HOLD - 1);
    localparam logic [31:0] c_STAGE_LAST = 32'(STAGE_DELAY - 1);
    localparam logic [1:0]  c_MAX_RETRY  = 2'(MAX_RETRY);
    localparam logic [NUM_STAGES-1:0] c_FIRST_STAGE = NUM_STAGES'(1);

    logic [2:0]            r_state;
    logic [31:0]           r_timer;
    logic [NUM_STAGES-1:0] r_stage_en;
    logic                  r_ready;
    logic                  r_pll_rst;
    logic                  r_fault;
    logic [1:0]            r_retry;

    logic [NUM_STAGES-1:0] w_stage_next;
    logic                  w_lock_lost;

    // Shifting a one in from the bottom keeps the enables thermometer-coded.
    assign w_stage_next = {r_stage_en[NUM_STAGES-2:0], 1'b1};

`ifdef RSEQ_LOCK_MONITOR_EN
    assign w_lock_lost = ~pll_locked;
`else
    assign w_lock_lost = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_HOLD;
            r_timer    <= '0;
            r_stage_en <= '0;
            r_ready    <= 1'b0;
            r_pll_rst  <= 1'b0;
            r_fault    <= 1'b0;
            r_retry    <= '0;
        end else begin
            case (r_state)
                c_ST_HOLD: begin
                    r_state <= c_ST_WAIT_LOCK;
                    r_timer <= '0;
                end

                c_ST_WAIT_LOCK: begin
                    // Lock wins over a timeout on the same edge.
                    if (pll_locked) begin
                        r_state    <= c_ST_STAGE;
                        r_stage_en <= c_FIRST_STAGE;
                        r_retry    <= '0;
                        r_timer    <= '0;
                    end else if (r_timer == c_LOCK_LAST) begin
                        r_timer <= '0;
                        if (r_retry == c_MAX_RETRY) begin
                            r_state    <= c_ST_FAULT;
                            r_fault    <= 1'b1;
                            r_pll_rst  <= 1'b1;
                            r_stage_en <= '0;
                        end else begin
                            r_state   <= c_ST_PLL_RESET;
                            r_retry   <= r_retry + 2'd1;
                            r_pll_rst <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end

                c_ST_PLL_RESET: begin
                    if (r_timer == c_HOLD_LAST) begin
                        r_state   <= c_ST_WAIT_LOCK;
                        r_pll_rst <= 1'b0;
                        r_timer   <= '0;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end

                c_ST_STAGE: begin
                    if (r_timer == c_STAGE_LAST) begin
                        r_timer    <= '0;
                        r_stage_en <= w_stage_next;
                        if (w_stage_next[NUM_STAGES-1]) begin
                            r_ready <= 1'b1;
                            r_state <= c_ST_RUN;
                        end
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end

                c_ST_RUN: begin
                    if (soft_rst_req || w_lock_lost) begin
                        r_state    <= c_ST_SOFT;
                        r_stage_en <= '0;
                        r_ready    <= 1'b0;
                        r_pll_rst  <= 1'b1;
                        r_timer    <= '0;
                    end
                end

                c_ST_SOFT: begin
                    // The retry count survives until the hold ends, so a
                    // fault clear still shows the exhausted count in SOFT.
                    if (r_timer == c_HOLD_LAST) begin
                        r_state   <= c_ST_WAIT_LOCK;
                        r_pll_rst <= 1'b0;
                        r_retry   <= '0;
                        r_timer   <= '0;
                    end else begin
                        r_timer <= r_timer + 32'd1;
                    end
                end

                c_ST_FAULT: begin
                    // pll_rst stays high into SOFT. Only fault drops here.
                    if (soft_rst_req) begin
                        r_state <= c_ST_SOFT;
                        r_fault <= 1'b0;
                        r_timer <= '0;
                    end
                end

                default: begin
                    r_state    <= c_ST_HOLD;
                    r_timer    <= '0;
                    r_stage_en <= '0;
                    r_ready    <= 1'b0;
                    r_pll_rst  <= 1'b0;
                    r_fault    <= 1'b0;
                    r_retry    <= '0;
                end
            endcase
        end
    end

    assign stage_en  = r_stage_en;
    assign ready     = r_ready;
    assign pll_rst   = r_pll_rst;
    assign fault     = r_fault;
    assign retry_cnt = r_retry;

endmodule
`default_nettype wire
